// File: rtl/population_evaluation_scheduler_pkg.sv
// Shared types and constants for the population evaluation scheduler.
// Fitness is the 35-bit sum of eight 32-bit per-lane error sums.
package population_evaluation_scheduler_pkg;

    localparam int FITNESS_W  = 35;
    localparam int NUM_LANES  = 8;
    localparam int LANE_W     = 32;
    localparam int LANE_CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        RUN,
        SUM,
        RECORD,
        RELEASE,
        BATCH_DONE
    } state_t;

endpackage

// File: rtl/population_evaluation_scheduler_fitness_accumulator.sv
// Serial 8-lane adder: one lane per cycle after start.
// done is high during the final add; sum is complete the following cycle.
module fitness_accumulator
    import population_evaluation_scheduler_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_LANES-1:0][LANE_W-1:0] lanes,
    output logic                             done,
    output logic [FITNESS_W-1:0]             sum
);

    logic                  busy;
    logic [LANE_CNT_W-1:0] lane;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            lane <= '0;
            sum  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            lane <= '0;
            sum  <= '0;
        end else if (busy) begin
            sum  <= sum + FITNESS_W'(lanes[lane]);
            lane <= lane + LANE_CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (lane == LANE_CNT_W'(NUM_LANES - 1));

endmodule

// File: rtl/population_evaluation_scheduler.sv
// Walks a population through the processor, records each fitness
// and tracks the lowest-fitness chromosome of the batch.
module population_evaluation_scheduler
    import population_evaluation_scheduler_pkg::*;
#(
    parameter int IDX_W      = 8,
    parameter int RD_LATENCY = 2,
    parameter int WATCHDOG   = 2000000
) (
    input  logic                             iClock,
    input  logic                             iReset,
    input  logic                             iStartBatch,
    input  logic [IDX_W-1:0]                 iPopulationSize,
    output logic [IDX_W-1:0]                 oChromIndex,
    output logic                             oStartProcessing,
    input  logic                             iReadyToProcess,
    input  logic                             iDoneProcessing,
    output logic                             oDoneProcessingFeedback,
    input  logic [NUM_LANES-1:0][LANE_W-1:0] iErrorSums,
    output logic                             oFitnessWrite,
    output logic [IDX_W-1:0]                 oFitnessAddr,
    output logic [FITNESS_W-1:0]             oFitnessValue,
    output logic [IDX_W-1:0]                 oBestIndex,
    output logic [FITNESS_W-1:0]             oBestFitness,
    output logic                             oBusy,
    output logic                             oBatchDone,
    output logic                             oStall
);

    localparam int LAT_W = $clog2(RD_LATENCY + 2);
    localparam int WD_W  = $clog2(WATCHDOG + 2);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LATENCY);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WATCHDOG);

    state_t                 state;
    state_t                 next_state;
    logic [IDX_W-1:0]       size;
    logic [IDX_W-1:0]       index;
    logic [IDX_W-1:0]       best_idx;
    logic [LAT_W-1:0]       lat_cnt;
    logic [WD_W-1:0]        wd_cnt;
    logic [FITNESS_W-1:0]   best;
    logic [FITNESS_W-1:0]   acc;
    logic                   stall;
    logic                   lat_done;
    logic                   last_idx;
    logic                   acc_start;
    logic                   acc_done;
    logic                   accept;

    assign lat_done  = (lat_cnt == LAT_MAX);
    assign last_idx  = (index == size - IDX_W'(1));
    assign acc_start = (state == RUN) && iDoneProcessing;
    assign accept    = iStartBatch &&
                       ((state == IDLE) || (state == BATCH_DONE));

    fitness_accumulator u_acc (
        .clk   (iClock),
        .rst   (iReset),
        .start (acc_start),
        .lanes (iErrorSums),
        .done  (acc_done),
        .sum   (acc)
    );

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, BATCH_DONE: begin
                if (iStartBatch) begin
                    next_state = (iPopulationSize == '0) ? BATCH_DONE : FETCH;
                end
            end
            FETCH: begin
                if (lat_done && iReadyToProcess) begin
                    next_state = START;
                end
            end
            START: next_state = RUN;
            RUN: begin
                if (iDoneProcessing) begin
                    next_state = SUM;
                end
            end
            SUM: begin
                if (acc_done) begin
                    next_state = RECORD;
                end
            end
            RECORD: next_state = RELEASE;
            RELEASE: begin
                if (iReadyToProcess) begin
                    next_state = last_idx ? BATCH_DONE : FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        oStartProcessing        = 1'b0;
        oDoneProcessingFeedback = 1'b0;
        oFitnessWrite           = 1'b0;
        oBusy                   = 1'b1;
        oBatchDone              = 1'b0;
        unique case (state)
            IDLE:       oBusy = 1'b0;
            BATCH_DONE: begin
                oBusy      = 1'b0;
                oBatchDone = 1'b1;
            end
            START:      oStartProcessing = 1'b1;
            RECORD:     oFitnessWrite = 1'b1;
            RELEASE:    oDoneProcessingFeedback = 1'b1;
            default:    oBusy = 1'b1;
        endcase
    end

    // Batch bookkeeping: index, fetch latency, watchdog and best tracking.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            size     <= '0;
            index    <= '0;
            lat_cnt  <= '0;
            wd_cnt   <= '0;
            stall    <= 1'b0;
            best     <= '1;
            best_idx <= '0;
        end else begin
            if (accept) begin
                size     <= iPopulationSize;
                index    <= '0;
                lat_cnt  <= '0;
                stall    <= 1'b0;
                best     <= '1;
                best_idx <= '0;
            end
            if (state == FETCH && !lat_done) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
            if (state == START) begin
                wd_cnt <= '0;
            end
            if (state == RUN) begin
                if (wd_cnt < WD_MAX) begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end else begin
                    stall <= 1'b1;
                end
            end
            if (state == RECORD && acc < best) begin
                best     <= acc;
                best_idx <= index;
            end
            if (state == RELEASE && iReadyToProcess && !last_idx) begin
                index   <= index + IDX_W'(1);
                lat_cnt <= '0;
            end
        end
    end

    assign oChromIndex   = index;
    assign oFitnessAddr  = index;
    assign oFitnessValue = acc;
    assign oBestIndex    = best_idx;
    assign oBestFitness  = best;
    assign oStall        = stall;

endmodule

// File: tb/tb_population_evaluation_scheduler.sv
// Bench for population_evaluation_scheduler: processor model, fitness
// scoreboard and per-batch checks of best, stall and handshakes.
module tb_population_evaluation_scheduler;
    import population_evaluation_scheduler_pkg::*;

    localparam int IDX_W = 8;
    localparam int WD    = 10;

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             start_batch;
    logic [IDX_W-1:0]                 pop_size;
    logic [IDX_W-1:0]                 chrom_idx;
    logic                             start_proc;
    logic                             ready;
    logic                             done_proc;
    logic                             fb;
    logic [NUM_LANES-1:0][LANE_W-1:0] err_sums;
    logic                             fit_wr;
    logic [IDX_W-1:0]                 fit_addr;
    logic [FITNESS_W-1:0]             fit_val;
    logic [IDX_W-1:0]                 best_idx;
    logic [FITNESS_W-1:0]             best_fit;
    logic                             busy;
    logic                             batch_done;
    logic                             stall;

    population_evaluation_scheduler #(
        .IDX_W(IDX_W), .RD_LATENCY(2), .WATCHDOG(WD)
    ) dut (
        .iClock(clk), .iReset(rst), .iStartBatch(start_batch),
        .iPopulationSize(pop_size), .oChromIndex(chrom_idx),
        .oStartProcessing(start_proc), .iReadyToProcess(ready),
        .iDoneProcessing(done_proc), .oDoneProcessingFeedback(fb),
        .iErrorSums(err_sums), .oFitnessWrite(fit_wr),
        .oFitnessAddr(fit_addr), .oFitnessValue(fit_val),
        .oBestIndex(best_idx), .oBestFitness(best_fit), .oBusy(busy),
        .oBatchDone(batch_done), .oStall(stall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Processor model state, shared with stimulus.
    logic [31:0]    tbl [0:255][0:7];
    int             p_state = 0;
    int             p_cnt = 0;
    logic [7:0]     p_idx = '0;
    int             run_min = 1;
    int             run_max = 3;
    int             cool_len = 0;

    // Scoreboard of expected {addr, fitness} writes.
    logic [42:0]    exp_q [$];
    int             write_cnt = 0;
    int             start_cnt = 0;
    int             fb_run = 0;
    int             fb_min = 1000;

    task automatic drive_proc();
        ready     = (p_state == 0);
        done_proc = (p_state == 2);
        for (int l = 0; l < 8; l++) begin
            err_sums[l] = (p_state == 2) ? tbl[p_idx][l] : $urandom;
        end
    endtask

    initial begin : processor
        logic s_start, s_fb;
        logic [7:0] s_idx;
        drive_proc();
        forever begin
            @(negedge clk);
            s_start = start_proc;
            s_fb    = fb;
            s_idx   = chrom_idx;
            if (s_start && !rst) check("start_when_idle", p_state == 0, 1);
            @(posedge clk);
            #1;
            if (rst) begin
                p_state = 0;
            end else begin
                case (p_state)
                    0: if (s_start) begin
                        p_state = 1;
                        p_cnt   = $urandom_range(run_max, run_min);
                        p_idx   = s_idx;
                    end
                    1: if (p_cnt <= 1) p_state = 2; else p_cnt--;
                    2: if (s_fb) begin
                        check("index_stable", s_idx, p_idx);
                        if (cool_len > 0) begin
                            p_state = 3;
                            p_cnt   = cool_len;
                        end else begin
                            p_state = 0;
                        end
                    end
                    default: if (p_cnt <= 1) p_state = 0; else p_cnt--;
                endcase
            end
            drive_proc();
        end
    end

    initial begin : monitor
        logic [42:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (start_proc) start_cnt++;
                if (fit_wr) begin
                    write_cnt++;
                    check("write_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("fit_addr", fit_addr, e[42:35]);
                        check("fit_value", fit_val, e[34:0]);
                    end
                end
                if (fb) begin
                    fb_run++;
                end else if (fb_run > 0) begin
                    if (fb_run < fb_min) fb_min = fb_run;
                    fb_run = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_batch_done"}, batch_done, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_write"}, fit_wr, 0);
        check({tag, "_start"}, start_proc, 0);
        check({tag, "_fb"}, fb, 0);
        check({tag, "_index"}, chrom_idx, 0);
        check({tag, "_best_idx"}, best_idx, 0);
        check({tag, "_best_fit"}, best_fit, {FITNESS_W{1'b1}});
        check({tag, "_fit_val"}, fit_val, 0);
    endtask

    // mode 0: small lanes (frequent ties), 1: full random,
    // 2: all ones, 3: idx0 all ones-per-lane then zeros.
    task automatic run_batch(input int size, input int mode, input int rmin,
                             input int rmax, input int cool, input bit poke);
        logic [34:0] s, best;
        int          bidx, n;
        best = '1;
        bidx = 0;
        for (int i = 0; i < size; i++) begin
            s = '0;
            for (int l = 0; l < 8; l++) begin
                case (mode)
                    0: tbl[i][l] = $urandom_range(3, 0);
                    1: tbl[i][l] = $urandom;
                    2: tbl[i][l] = 32'hFFFF_FFFF;
                    default: tbl[i][l] = (i == 0) ? 32'd1 : 32'd0;
                endcase
                s = s + {3'b000, tbl[i][l]};
            end
            exp_q.push_back({i[7:0], s});
            if (s < best) begin
                best = s;
                bidx = i;
            end
        end
        run_min = rmin;
        run_max = rmax;
        cool_len = cool;
        write_cnt = 0;
        start_cnt = 0;
        fb_min = 1000;
        @(negedge clk);
        pop_size = size[7:0];
        start_batch = 1'b1;
        @(negedge clk);
        start_batch = 1'b0;
        check("stall_cleared", stall, 0);
        if (size == 0) check("empty_batch_done", batch_done, 1);
        if (poke) begin
            repeat (3) @(negedge clk);
            pop_size = 8'd1;
            start_batch = 1'b1;
            @(negedge clk);
            start_batch = 1'b0;
        end
        n = 0;
        while (!batch_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("batch_finished", n < 20000, 1);
        @(negedge clk);
        check("still_done", batch_done, 1);
        check("idle_busy", busy, 0);
        check("write_count", write_cnt, size);
        check("start_count", start_cnt, size);
        check("queue_empty", exp_q.size(), 0);
        check("best_fitness", best_fit, best);
        check("best_index", best_idx, bidx);
        check("stall", stall, rmin > WD);
        if (cool > 0) check("fb_held", fb_min >= cool, 1);
        exp_q.delete();
    endtask

    initial begin : guard
        #5000000;
        $display("FAIL timeout: simulation did not end");
        $fatal(1);
    end

    initial begin : stim
        int n;
        rst = 1'b1;
        start_batch = 1'b0;
        pop_size = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        run_batch(3, 3, 1, 4, 0, 0);
        run_batch(0, 0, 1, 4, 0, 0);
        run_batch(1, 2, 1, 4, 0, 0);
        check("all_ones_fit", best_fit, 35'h7_FFFF_FFF8);
        run_batch(3, 1, 1, 4, 5, 1);
        run_batch(2, 1, 20, 20, 0, 0);
        run_batch(2, 1, 1, 3, 0, 0);
        repeat (4) begin
            run_batch($urandom_range(6, 1), $urandom_range(1, 0), 1, 5,
                      $urandom_range(2, 0), 0);
        end
        run_batch(255, 0, 1, 3, 0, 0);

        // Reset while the processor is running.
        exp_q.delete();
        run_min = 8;
        run_max = 8;
        cool_len = 0;
        @(negedge clk);
        pop_size = 8'd4;
        start_batch = 1'b1;
        @(negedge clk);
        start_batch = 1'b0;
        n = 0;
        while (p_state != 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_run", n < 100, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_run");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_batch(2, 1, 1, 3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
